// File: rtl/s_axi_read_pipe.sv
`default_nettype none
// ============================================================================
// Module   : s_axi_read_pipe
// Purpose  : AXI4-Lite read slave for the sequencer register file. Decodes
//            bank0 (flat control/status registers) and bank1 (per-slot
//            descriptor table, fetched through a req/ready handshake), returns
//            SLVERR/DECERR for bad addresses, and buffers every result in a
//            response FIFO so address acceptance is decoupled from R-channel
//            backpressure.
// Ports    : clk                   clock
//            reset                 asynchronous, active-low reset
//            S_AXI_AR*             read address channel (ARADDR[15:0] decoded)
//            S_AXI_R*              read data channel, driven from FIFO head
//            ext_bank0_rdata_flat  bank0 register k at [k*DATA_WIDTH +: DATA_WIDTH]
//            ext_bank1_out_*       bank1 slot/field select, req, rdata, ready
// Options  : S_AXI_READ_TIMEOUT_EN - abandon a bank1 wait after
//            TIMEOUT_CYCLES cycles with an SLVERR response.
// Revision : 1.0 - initial release
// ============================================================================
module s_axi_read_pipe #(
    parameter int ADDR_WIDTH        = 16,
    parameter int DATA_WIDTH        = 32,
    parameter int BANK0_NUM_REGS    = 8,
    parameter int BANK1_INDEX_WIDTH = 3,
    parameter int BANK1_NUM_FIELDS  = 6,
    parameter int FIFO_DEPTH        = 4,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [ADDR_WIDTH-1:0]                S_AXI_ARADDR,
    input  logic                                 S_AXI_ARVALID,
    output logic                                 S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                S_AXI_RDATA,
    output logic [1:0]                           S_AXI_RRESP,
    output logic                                 S_AXI_RVALID,
    input  logic                                 S_AXI_RREADY,
    input  logic [BANK0_NUM_REGS*DATA_WIDTH-1:0] ext_bank0_rdata_flat,
    output logic [BANK1_INDEX_WIDTH-1:0]         ext_bank1_out_index,
    output logic [3:0]                           ext_bank1_out_field,
    output logic                                 ext_bank1_out_req,
    input  logic [DATA_WIDTH-1:0]                ext_bank1_out_rdata,
    input  logic                                 ext_bank1_out_ready
);

    localparam int                 c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                 c_CNT_W    = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [8:0]         c_B0_LIMIT = 9'(BANK0_NUM_REGS);
    localparam logic [4:0]         c_B1_LIMIT = 5'(BANK1_NUM_FIELDS);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DECODE  = 2'd1;
    localparam logic [1:0] ST_WAIT_B1 = 2'd2;
    localparam logic [1:0] ST_PUSH    = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [15:2]           r_addr_q;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic [1:0]            r_res_resp;
    logic [DATA_WIDTH-1:0] w_res_data;
    logic [1:0]            w_res_resp;
    logic                  w_res_load;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_arready;
    logic                  w_b1_req;
    logic                  w_timeout;
    logic [7:0]            w_reg_idx;
    logic [3:0]            w_field;
    logic [DATA_WIDTH-1:0] w_b0_data;

    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [1:0]            r_fifo_resp [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    // Only ARADDR[15:2] carries meaning; the rest is deliberately dropped.
    logic w_unused_addr_lo;
    assign w_unused_addr_lo = ^S_AXI_ARADDR[1:0];
    generate
        if (ADDR_WIDTH > 16) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^S_AXI_ARADDR[ADDR_WIDTH-1:16];
        end
    endgenerate

    assign w_reg_idx = r_addr_q[13:6];
    assign w_field   = r_addr_q[5:2];

    // Bank0 mux; out-of-range indices fall through to zero.
    always_comb begin
        w_b0_data = '0;
        for (int k = 0; k < BANK0_NUM_REGS; k++) begin
            if (w_reg_idx == 8'(k)) begin
                w_b0_data = ext_bank0_rdata_flat[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef S_AXI_READ_TIMEOUT_EN
    localparam int                c_TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
    logic [c_TO_W-1:0] r_wait_cnt;

    // Held at zero outside the wait state, so each wait starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT_B1) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign w_timeout = (r_wait_cnt == c_TO_LAST);
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_res_load  = 1'b0;
        w_res_data  = '0;
        w_res_resp  = c_RESP_OKAY;
        w_push      = 1'b0;
        w_arready   = 1'b0;
        w_b1_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A free FIFO slot is reserved before accepting, so the
                // later push can never find the FIFO full.
                w_arready = S_AXI_ARVALID && (r_count < c_DEPTH);
                if (w_arready) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (r_addr_q[15:14])
                    2'b00: begin
                        w_res_load  = 1'b1;
                        w_state_nxt = ST_PUSH;
                        if ({1'b0, w_reg_idx} < c_B0_LIMIT) begin
                            w_res_data = w_b0_data;
                        end else begin
                            w_res_resp = c_RESP_SLVERR;
                        end
                    end
                    2'b01: begin
                        if ({1'b0, w_field} < c_B1_LIMIT) begin
                            w_state_nxt = ST_WAIT_B1;
                        end else begin
                            w_res_load  = 1'b1;
                            w_res_resp  = c_RESP_SLVERR;
                            w_state_nxt = ST_PUSH;
                        end
                    end
                    default: begin
                        w_res_load  = 1'b1;
                        w_res_resp  = c_RESP_DECERR;
                        w_state_nxt = ST_PUSH;
                    end
                endcase
            end
            ST_WAIT_B1: begin
                w_b1_req = 1'b1;
                // ready takes priority over a coincident timeout.
                if (ext_bank1_out_ready) begin
                    w_res_load  = 1'b1;
                    w_res_data  = ext_bank1_out_rdata;
                    w_state_nxt = ST_PUSH;
                end else if (w_timeout) begin
                    w_res_load  = 1'b1;
                    w_res_resp  = c_RESP_SLVERR;
                    w_state_nxt = ST_PUSH;
                end
            end
            ST_PUSH: begin
                w_push      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_q   <= '0;
            r_res_data <= '0;
            r_res_resp <= c_RESP_OKAY;
        end else begin
            if (w_arready) begin
                r_addr_q <= S_AXI_ARADDR[15:2];
            end
            if (w_res_load) begin
                r_res_data <= w_res_data;
                r_res_resp <= w_res_resp;
            end
        end
    end

    assign w_pop = S_AXI_RVALID && S_AXI_RREADY;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_resp[i] <= c_RESP_OKAY;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= r_res_data;
                r_fifo_resp[r_wr_ptr] <= r_res_resp;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign S_AXI_ARREADY       = w_arready;
    assign S_AXI_RVALID        = (r_count != '0);
    assign S_AXI_RDATA         = r_fifo_data[r_rd_ptr];
    assign S_AXI_RRESP         = r_fifo_resp[r_rd_ptr];
    assign ext_bank1_out_req   = w_b1_req;
    assign ext_bank1_out_index = r_addr_q[6 +: BANK1_INDEX_WIDTH];
    assign ext_bank1_out_field = w_field;

endmodule
`default_nettype wire

// File: doc/s_axi_read_pipe.md
# s_axi_read_pipe

Parametrised AXI4-Lite read slave for the sequencer register file, the next generation of the single-transaction read block. It decodes bank0 (flat control/status registers) and bank1 (per-slot descriptor table), waits on a bank1 request/ready handshake instead of assuming same-cycle data, and returns error responses for bad addresses. Results are buffered in a response FIFO so address acceptance is decoupled from R-channel backpressure.

## Interface
- ADDR_WIDTH, 16, AR address width; must be ≥ 16.
- DATA_WIDTH, 32, R data and register width.
- BANK0_NUM_REGS, 8, number of bank0 registers.
- BANK1_INDEX_WIDTH, 3, bank1 slot index width.
- BANK1_NUM_FIELDS, 6, valid bank1 field selects 0..N-1; N ≤ 16.
- FIFO_DEPTH, 4, response FIFO entries; power of two, ≥ 2.
- TIMEOUT_CYCLES, 255, bank1 wait limit; used only with the timeout macro.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARVALID  in  1  address valid.
- S_AXI_ARREADY  out  1  address accepted.
- S_AXI_RDATA  out  DATA_WIDTH  read data from the FIFO head.
- S_AXI_RRESP  out  2  OKAY=00, SLVERR=10, DECERR=11.
- S_AXI_RVALID  out  1  FIFO non-empty.
- S_AXI_RREADY  in  1  master ready.
- ext_bank0_rdata_flat  in  BANK0_NUM_REGS*DATA_WIDTH  register k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- ext_bank1_out_index  out  BANK1_INDEX_WIDTH  slot select.
- ext_bank1_out_field  out  4  field select.
- ext_bank1_out_req  out  1  bank1 read request, held until ready.
- ext_bank1_out_rdata  in  DATA_WIDTH  bank1 data, valid when ready is high.
- ext_bank1_out_ready  in  1  bank1 data valid and request complete.

## Operation
- FSM states:
  - ST_IDLE.
  - ST_DECODE.
  - ST_WAIT_B1.
  - ST_PUSH.
- ST_IDLE:
  - S_AXI_ARREADY = S_AXI_ARVALID && fifo_count < FIFO_DEPTH.
  - On handshake, latch ARADDR into addr_q and go to ST_DECODE.
- ST_DECODE, classified on addr_q[15:14]:
  - 00, bank0: reg = addr_q[13:6]. If reg < BANK0_NUM_REGS, result = register value with OKAY; otherwise data 0 with SLVERR. Go to ST_PUSH.
  - 01, bank1: field = addr_q[5:2]. If field < BANK1_NUM_FIELDS, go to ST_WAIT_B1; otherwise data 0 with SLVERR, go to ST_PUSH, and req never asserts.
  - 10 or 11: data 0 with DECERR, go to ST_PUSH.
- ST_WAIT_B1:
  - ext_bank1_out_req = 1.
  - index = addr_q[6+BANK1_INDEX_WIDTH-1:6] and field = addr_q[5:2], both stable for the whole request.
  - When ready = 1, capture rdata with OKAY and go to ST_PUSH. req drops the next cycle.
  - ready outside ST_WAIT_B1 is ignored.
- ST_PUSH:
  - Write {data, resp} into the FIFO and return to ST_IDLE.
  - The FIFO cannot be full here: ARREADY gated on a free entry, and only one request is in flight.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)-bit pointers; wrap modulo depth.
  - Count width log2(FIFO_DEPTH)+1.
  - Pop on RVALID && RREADY.
  - Push and pop in the same cycle leave the count unchanged; both pointers advance.
  - RDATA and RRESP are stable while RVALID is high and RREADY is low.
- Address bits above 15 are ignored.
- ext_bank1_out_index and ext_bank1_out_field are driven from addr_q at all times. Only req qualifies them.

## Timing
- Reset values:
  - state = ST_IDLE.
  - FIFO empty, pointers 0.
  - ARREADY 0, RVALID 0.
  - RDATA 0, RRESP 00.
  - req 0.
  - addr_q 0, so index and field outputs are 0.
- Bank0 or error path, with AR handshake in cycle N:
  - N+1: ST_DECODE.
  - N+2: ST_PUSH.
  - N+3: RVALID = 1 (FIFO was empty).
  - Next ARREADY no earlier than N+3.
- Bank1 path:
  - req is high from N+2.
  - With ready sampled in cycle M, RVALID rises at M+2.
- Sustained throughput is one transaction per 3 cycles (bank0).
- With RREADY held low, FIFO_DEPTH transactions complete. ARREADY then stays 0 until a pop; the freed entry is visible the cycle after the pop.
- Reset asserted mid-transaction:
  - Clears the FSM and FIFO immediately.
  - The in-flight request is dropped.
  - req deasserts asynchronously.

## Configuration
- S_AXI_READ_TIMEOUT_EN defined:
  - A wait counter runs in ST_WAIT_B1.
  - If ready is not seen after TIMEOUT_CYCLES cycles with req high, push data 0 with SLVERR and drop req.
  - The counter clears on entering ST_WAIT_B1.
  - ready arriving in the same cycle as the timeout wins (OKAY).
- Not defined: the block waits indefinitely for ready, and no counter is synthesised.

## Test plan
- Bank0 read: set reg 4 = 0x1234_5678, read address 0x0100 with RREADY = 1 → RDATA 0x1234_5678, RRESP 00, RVALID 3 cycles after AR handshake.
- Unmapped addresses:
  - 0x0200 (reg 8) → data 0, SLVERR.
  - 0x8000 → data 0, DECERR.
  - Bank1 field 7 (0x405C) → SLVERR, req never high.
- Bank1 wait: read 0x4188 (index 6, field 2), ready after 5 cycles with rdata 0xCAFE_0002 → index = 6, field = 2, req high exactly until the ready cycle; RDATA 0xCAFE_0002 with OKAY.
- Backpressure: RREADY = 0, issue 5 bank0 reads → 4 accepted, ARREADY stays 0. Then pulse RREADY → data returns in order, and the 5th read is accepted after the first pop.
- Timeout (macro on, TIMEOUT_CYCLES = 10): bank1 read, ready never asserted → SLVERR, data 0, req low after 10 cycles. Repeat with ready on cycle 10 → OKAY.
- Reset mid-flight: assert reset while in ST_WAIT_B1 with 2 FIFO entries → RVALID and req 0 immediately; a new read after release is serviced normally.
